// File: rtl/cicero_cmd_sequencer.sv
// Hardware job engine for the CICERO register block: loads a program image,
// starts the core, polls for completion, reads elapsed cycles and restarts it.
module cicero_cmd_sequencer #(
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned WORD_CNT_WIDTH = 10,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [WORD_CNT_WIDTH-1:0] job_words,
  input  logic [REG_WIDTH-1:0]      job_start_cc,
  input  logic [REG_WIDTH-1:0]      job_end_cc,
  input  logic                      prog_valid,
  output logic                      prog_ready,
  input  logic [REG_WIDTH-1:0]      prog_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_accept,
  output logic                      res_error,
  output logic                      res_timeout,
  output logic [REG_WIDTH-1:0]      res_elapsed,
  output logic [REG_WIDTH-1:0]      cmd_register,
  output logic [REG_WIDTH-1:0]      address_register,
  output logic [REG_WIDTH-1:0]      data_in_register,
  output logic [REG_WIDTH-1:0]      start_cc_pointer_register,
  output logic [REG_WIDTH-1:0]      end_cc_pointer_register,
  input  logic [REG_WIDTH-1:0]      status_register,
  input  logic [REG_WIDTH-1:0]      data_o_register
);

  localparam logic [REG_WIDTH-1:0] CMD_NOP                = REG_WIDTH'(0);
  localparam logic [REG_WIDTH-1:0] CMD_WRITE              = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] CMD_START              = REG_WIDTH'(2);
  localparam logic [REG_WIDTH-1:0] CMD_RESET              = REG_WIDTH'(4);
  localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = REG_WIDTH'(5);
  localparam logic [REG_WIDTH-1:0] CMD_RESTART            = REG_WIDTH'(6);

  localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = REG_WIDTH'(0);
  localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = REG_WIDTH'(2);
  localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = REG_WIDTH'(3);
  localparam logic [REG_WIDTH-1:0] STATUS_ERROR    = REG_WIDTH'(4);

  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_READ_CC,
    S_RESTART,
    S_RESP
  } state_t;

  state_t                    state_q, state_d;
  logic [WORD_CNT_WIDTH-1:0] words_q, words_d;
  logic [WORD_CNT_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]               tmr_q, tmr_d;
  logic [31:0]               tmr_inc;
  logic                      timeout_hit;
  logic                      terminal;

  logic [REG_WIDTH-1:0] cmd_d, addr_d, data_d, start_d, end_d, ela_d;
  logic                 acc_d, err_d, tmo_d;
  logic                 job_ready_d, prog_ready_d, res_valid_d;

  assign tmr_inc     = (&tmr_q) ? tmr_q : tmr_q + 32'd1;
  assign timeout_hit = (TMO_LIMIT != '0) && (tmr_inc >= TMO_LIMIT);
  assign terminal    = (status_register == STATUS_ACCEPTED) ||
                       (status_register == STATUS_REJECTED) ||
                       (status_register == STATUS_ERROR);

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    cmd_d   = CMD_NOP;
    addr_d  = address_register;
    data_d  = data_in_register;
    start_d = start_cc_pointer_register;
    end_d   = end_cc_pointer_register;
    ela_d   = res_elapsed;
    acc_d   = res_accept;
    err_d   = res_error;
    tmo_d   = res_timeout;

    case (state_q)
      S_IDLE: begin
        if (job_valid && job_ready) begin
          words_d = job_words;
          idx_d   = '0;
          start_d = job_start_cc;
          end_d   = job_end_cc;
          state_d = (job_words == '0) ? S_START : S_LOAD;
        end
      end
      S_LOAD: begin
        if (prog_valid && prog_ready) begin
          cmd_d  = CMD_WRITE;
          addr_d = REG_WIDTH'(idx_q);
          data_d = prog_data;
          idx_d  = idx_q + WORD_CNT_WIDTH'(1);
          if (idx_q == words_q - WORD_CNT_WIDTH'(1)) state_d = S_START;
        end
      end
      S_START: begin
        cmd_d = CMD_START;
        if (status_register != STATUS_IDLE) begin
          cmd_d   = CMD_NOP;
          tmr_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // terminal status is checked first so it wins a same-cycle timeout
        if (terminal) begin
          acc_d   = (status_register == STATUS_ACCEPTED);
          err_d   = (status_register == STATUS_ERROR);
          cmd_d   = CMD_READ_ELAPSED_CLOCK;
          state_d = S_READ_CC;
        end else if (timeout_hit) begin
          cmd_d   = CMD_RESET;
          tmo_d   = 1'b1;
          ela_d   = '1;
          state_d = S_RESP;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_READ_CC: begin
        ela_d   = data_o_register;
        cmd_d   = CMD_RESTART;
        state_d = S_RESTART;
      end
      S_RESTART: begin
        cmd_d = CMD_RESTART;
        if (status_register == STATUS_IDLE) begin
          cmd_d   = CMD_NOP;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (res_valid && res_ready) begin
          acc_d   = 1'b0;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    job_ready_d  = (state_d == S_IDLE);
    prog_ready_d = (state_d == S_LOAD);
    res_valid_d  = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                   <= S_IDLE;
      words_q                   <= '0;
      idx_q                     <= '0;
      tmr_q                     <= '0;
      cmd_register              <= CMD_NOP;
      address_register          <= '0;
      data_in_register          <= '0;
      start_cc_pointer_register <= '0;
      end_cc_pointer_register   <= '0;
      res_elapsed               <= '0;
      res_accept                <= 1'b0;
      res_error                 <= 1'b0;
      res_timeout               <= 1'b0;
      job_ready                 <= 1'b0;
      prog_ready                <= 1'b0;
      res_valid                 <= 1'b0;
    end else begin
      state_q                   <= state_d;
      words_q                   <= words_d;
      idx_q                     <= idx_d;
      tmr_q                     <= tmr_d;
      cmd_register              <= cmd_d;
      address_register          <= addr_d;
      data_in_register          <= data_d;
      start_cc_pointer_register <= start_d;
      end_cc_pointer_register   <= end_d;
      res_elapsed               <= ela_d;
      res_accept                <= acc_d;
      res_error                 <= err_d;
      res_timeout               <= tmo_d;
      job_ready                 <= job_ready_d;
      prog_ready                <= prog_ready_d;
      res_valid                 <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_cicero_cmd_sequencer.sv
// Scoreboard bench for cicero_cmd_sequencer with a behavioural CICERO core model.
module tb_cicero_cmd_sequencer;

  localparam logic [31:0] CMD_NOP                = 32'd0;
  localparam logic [31:0] CMD_WRITE              = 32'd1;
  localparam logic [31:0] CMD_START              = 32'd2;
  localparam logic [31:0] CMD_RESET              = 32'd4;
  localparam logic [31:0] CMD_READ_ELAPSED_CLOCK = 32'd5;
  localparam logic [31:0] CMD_RESTART            = 32'd6;
  localparam logic [31:0] ST_IDLE     = 32'd0;
  localparam logic [31:0] ST_RUNNING  = 32'd1;
  localparam logic [31:0] ST_ACCEPTED = 32'd2;
  localparam logic [31:0] ST_REJECTED = 32'd3;
  localparam logic [31:0] ST_ERROR    = 32'd4;
  localparam int unsigned TMO = 16;

  logic        clk, rst;
  logic        job_valid, job_ready;
  logic [9:0]  job_words;
  logic [31:0] job_start_cc, job_end_cc;
  logic        prog_valid, prog_ready;
  logic [31:0] prog_data;
  logic        res_valid, res_ready;
  logic        res_accept, res_error, res_timeout;
  logic [31:0] res_elapsed;
  logic [31:0] cmd_register, address_register, data_in_register;
  logic [31:0] start_cc_pointer_register, end_cc_pointer_register;
  logic [31:0] status_register, data_o_register;

  cicero_cmd_sequencer #(
    .REG_WIDTH      (32),
    .WORD_CNT_WIDTH (10),
    .TIMEOUT_CYCLES (TMO)
  ) u_dut (
    .clk                       (clk),
    .rst                       (rst),
    .job_valid                 (job_valid),
    .job_ready                 (job_ready),
    .job_words                 (job_words),
    .job_start_cc              (job_start_cc),
    .job_end_cc                (job_end_cc),
    .prog_valid                (prog_valid),
    .prog_ready                (prog_ready),
    .prog_data                 (prog_data),
    .res_valid                 (res_valid),
    .res_ready                 (res_ready),
    .res_accept                (res_accept),
    .res_error                 (res_error),
    .res_timeout               (res_timeout),
    .res_elapsed               (res_elapsed),
    .cmd_register              (cmd_register),
    .address_register          (address_register),
    .data_in_register          (data_in_register),
    .start_cc_pointer_register (start_cc_pointer_register),
    .end_cc_pointer_register   (end_cc_pointer_register),
    .status_register           (status_register),
    .data_o_register           (data_o_register)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: RUNNING on START, terminal after cfg_len running cycles (0 = never)
  logic [31:0] m_status, m_elapsed, cfg_len, cfg_term;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_status  <= ST_IDLE;
      m_elapsed <= 32'd0;
    end else if (cmd_register == CMD_RESET) begin
      m_status <= ST_IDLE;
    end else if (cmd_register == CMD_START && m_status == ST_IDLE) begin
      m_status  <= ST_RUNNING;
      m_elapsed <= 32'd0;
    end else if (cmd_register == CMD_RESTART &&
                 (m_status == ST_ACCEPTED || m_status == ST_REJECTED || m_status == ST_ERROR)) begin
      m_status <= ST_IDLE;
    end else if (m_status == ST_RUNNING) begin
      m_elapsed <= m_elapsed + 32'd1;
      if (cfg_len != 0 && m_elapsed + 32'd1 == cfg_len) m_status <= cfg_term;
    end
  end
  assign status_register = m_status;
  assign data_o_register = (cmd_register == CMD_READ_ELAPSED_CLOCK) ? m_elapsed : 32'd0;

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned len;   // 0 = any run length
  } ev_t;
  typedef struct {
    logic        acc;
    logic        err;
    logic        tmo;
    logic [31:0] ela;
  } res_t;

  ev_t  evq[$];
  res_t resq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic ev_en = 1'b0;
  logic drain = 1'b0;
  logic drained = 1'b0;

  logic [31:0] run_cmd, run_addr, run_data;
  int unsigned run_len = 0;

  task automatic emit(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d,
                      input int unsigned len);
    ev_t e;
    n_vec++;
    if (evq.size() == 0) begin
      n_bad++;
      $display("FAIL cmd_event @%0t: got cmd=%0d addr=%0d data=%h len=%0d, expected no event",
               $time, c, a, d, len);
    end else begin
      e = evq.pop_front();
      if (c != e.cmd || (e.cmd == CMD_WRITE && (a != e.addr || d != e.data)) ||
          (e.len != 0 && len != e.len)) begin
        n_bad++;
        $display("FAIL cmd_event @%0t: got cmd=%0d addr=%0d data=%h len=%0d, expected cmd=%0d addr=%0d data=%h len=%0d",
                 $time, c, a, d, len, e.cmd, e.addr, e.data, e.len);
      end
    end
  endtask

  // Monitor: the only process that counts and judges comparisons
  always @(negedge clk) begin
    if (rst) begin
      n_vec++;
      if (cmd_register != CMD_NOP || address_register != 0 || data_in_register != 0 ||
          start_cc_pointer_register != 0 || end_cc_pointer_register != 0 ||
          job_ready || prog_ready || res_valid || res_accept || res_error || res_timeout ||
          res_elapsed != 0) begin
        n_bad++;
        $display("FAIL reset_state @%0t: cmd=%0d addr=%0d data=%h sp=%h ep=%h jr=%b pr=%b rv=%b flags=%b%b%b ela=%h, required all zero",
                 $time, cmd_register, address_register, data_in_register, start_cc_pointer_register,
                 end_cc_pointer_register, job_ready, prog_ready, res_valid, res_accept, res_error,
                 res_timeout, res_elapsed);
      end
    end
    if (ev_en) begin
      if (run_len != 0 && (cmd_register != run_cmd || run_cmd == CMD_WRITE)) begin
        emit(run_cmd, run_addr, run_data, run_len);
        run_len = 0;
      end
      if (run_len == 0) begin
        run_cmd  = cmd_register;
        run_addr = address_register;
        run_data = data_in_register;
      end
      run_len++;
    end
    if (res_valid) begin
      n_vec++;
      if (resq.size() == 0) begin
        n_bad++;
        $display("FAIL result @%0t: res_valid=1, expected no result", $time);
      end else if (res_accept != resq[0].acc || res_error != resq[0].err ||
                   res_timeout != resq[0].tmo || res_elapsed != resq[0].ela ||
                   (!res_ready && job_ready)) begin
        n_bad++;
        $display("FAIL result @%0t: got acc=%b err=%b tmo=%b ela=%h jr=%b, expected acc=%b err=%b tmo=%b ela=%h jr=0",
                 $time, res_accept, res_error, res_timeout, res_elapsed, job_ready,
                 resq[0].acc, resq[0].err, resq[0].tmo, resq[0].ela);
      end
      if (res_ready && resq.size() != 0) void'(resq.pop_front());
    end
    if (drain && !drained) begin
      n_vec++;
      if (evq.size() != 0 || resq.size() != 0) begin
        n_bad++;
        $display("FAIL drain: %0d cmd events and %0d results left, expected 0 and 0",
                 evq.size(), resq.size());
      end
      drained = 1'b1;
    end
  end

  logic [31:0] prog_img [0:7];

  task automatic bump(inout int n, input string what);
    n++;
    if (n > 500) begin
      $display("FAIL wait_%s: no response within 500 cycles", what);
      $fatal(1, "bench stalled");
    end
  endtask

  task automatic push_prefix(input int unsigned nw, input int bubble_at);
    evq.push_back('{CMD_NOP, 32'd0, 32'd0, 0});
    for (int unsigned i = 0; i < nw; i++) begin
      evq.push_back('{CMD_WRITE, 32'(i), prog_img[i], 1});
      if (int'(i) == bubble_at) evq.push_back('{CMD_NOP, 32'd0, 32'd0, 1});
    end
    evq.push_back('{CMD_START, 32'd0, 32'd0, 0});
  endtask

  task automatic push_done(input int unsigned l, input logic [31:0] term);
    evq.push_back('{CMD_NOP, 32'd0, 32'd0, l});
    evq.push_back('{CMD_READ_ELAPSED_CLOCK, 32'd0, 32'd0, 1});
    evq.push_back('{CMD_RESTART, 32'd0, 32'd0, 0});
    resq.push_back('{term == ST_ACCEPTED, term == ST_ERROR, 1'b0, l});
    cfg_len  = l;
    cfg_term = term;
  endtask

  task automatic issue(input int unsigned nw, input int bubble_at,
                       input logic [31:0] sc, input logic [31:0] ec);
    int n = 0;
    job_words    = 10'(nw);
    job_start_cc = sc;
    job_end_cc   = ec;
    job_valid    = 1'b1;
    @(negedge clk);
    while (!job_ready) begin bump(n, "job_ready"); @(negedge clk); end
    @(posedge clk); #1;
    job_valid = 1'b0;
    for (int unsigned i = 0; i < nw; i++) begin
      prog_valid = 1'b1;
      prog_data  = prog_img[i];
      n = 0;
      @(negedge clk);
      while (!prog_ready) begin bump(n, "prog_ready"); @(negedge clk); end
      @(posedge clk); #1;
      prog_valid = 1'b0;
      if (int'(i) == bubble_at) begin @(posedge clk); #1; end
    end
  endtask

  task automatic take_result(input int hold);
    int n = 0;
    @(negedge clk);
    while (!res_valid) begin bump(n, "res_valid"); @(negedge clk); end
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; job_valid = 1'b0; job_words = '0; job_start_cc = '0; job_end_cc = '0;
    prog_valid = 1'b0; prog_data = '0; res_ready = 1'b0; cfg_len = '0; cfg_term = ST_ACCEPTED;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ev_en = 1'b1;

    // three words back-to-back, accepted after 5 cycles
    prog_img[0] = 32'hA; prog_img[1] = 32'hB; prog_img[2] = 32'hC;
    push_prefix(3, -1); push_done(5, ST_ACCEPTED);
    issue(3, -1, 32'h100, 32'h1FF); take_result(0);

    // one-cycle bubble after word 1; result held 5 cycles with res_ready low
    prog_img[0] = 32'h11; prog_img[1] = 32'h22; prog_img[2] = 32'h33;
    push_prefix(3, 1); push_done(12, ST_ACCEPTED);
    issue(3, 1, 32'h200, 32'h2FF); take_result(5);

    push_prefix(0, -1); push_done(7, ST_ERROR);
    issue(0, -1, 32'h300, 32'h3FF); take_result(0);

    prog_img[0] = 32'hDEADBEEF;
    push_prefix(1, -1); push_done(3, ST_REJECTED);
    issue(1, -1, 32'h400, 32'h4FF); take_result(1);

    // terminal status arrives in the same RUN cycle the timeout would fire
    push_prefix(0, -1); push_done(TMO, ST_ACCEPTED);
    issue(0, -1, 32'h500, 32'h5FF); take_result(0);

    // core never finishes: forced one-cycle CMD_RESET
    prog_img[0] = 32'h0F0F0F0F; prog_img[1] = 32'hF0F0F0F0;
    push_prefix(2, -1);
    evq.push_back('{CMD_NOP, 32'd0, 32'd0, TMO});
    evq.push_back('{CMD_RESET, 32'd0, 32'd0, 1});
    resq.push_back('{1'b0, 1'b0, 1'b1, 32'hFFFFFFFF});
    cfg_len = 0;
    issue(2, -1, 32'h600, 32'h6FF); take_result(2);

    // asynchronous reset while RUN: job aborted, no result
    push_prefix(0, -1);
    cfg_len = 0;
    issue(0, -1, 32'h55, 32'h66);
    n = 0;
    while (cmd_register != CMD_START) begin bump(n, "cmd_start"); @(negedge clk); end
    while (cmd_register != CMD_NOP) begin bump(n, "cmd_run"); @(negedge clk); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // recovery after reset
    prog_img[0] = 32'h12345678;
    push_prefix(1, -1); push_done(4, ST_ACCEPTED);
    issue(1, -1, 32'h700, 32'h7FF); take_result(0);

    repeat (5) @(negedge clk);
    drain = 1'b1;
    n = 0;
    @(negedge clk);
    while (!drained) begin bump(n, "drain"); @(negedge clk); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
